// File: rtl/systolic_mac_pe.sv
// Systolic-array MAC processing element: east/south operand forwarding, K_LEN-long
// dot product, and a per-column result shift chain. Define SATURATE_EN for a clamping accumulator.
module systolic_mac_pe #(
    parameter int DATA_W = 8,
    parameter int K_LEN  = 8,
    parameter int ACC_W  = 2*DATA_W + $clog2(K_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [DATA_W-1:0] north_data,
    input  logic              north_vld,
    input  logic [DATA_W-1:0] west_data,
    input  logic              west_vld,
    output logic [DATA_W-1:0] south_data,
    output logic              south_vld,
    output logic [DATA_W-1:0] east_data,
    output logic              east_vld,
    output logic [ACC_W-1:0]  acc_out,
    output logic              done,
    input  logic              unload,
    input  logic [ACC_W-1:0]  res_in,
    input  logic              res_in_vld,
    output logic [ACC_W-1:0]  res_out,
    output logic              res_out_vld,
    output logic              ovf
);

    localparam int CNT_W = $clog2(K_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K_LEN - 1);

    generate
        if (ACC_W < 2*DATA_W) begin : g_bad_acc_w
            $error("systolic_mac_pe: ACC_W must be >= 2*DATA_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_ACC  = 2'd0,
        ST_DONE = 2'd1,
        ST_PASS = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]          count;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [ACC_W-1:0]   acc_nxt;
    logic                      fire;
    logic                      emit;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nxt = state;
        fire      = 1'b0;
        emit      = 1'b0;
        if (clear) begin
            state_nxt = ST_ACC;
        end else begin
            case (state)
                ST_ACC: begin
                    fire = north_vld & west_vld;
                    if (fire && count == CNT_LAST) begin
                        state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (unload) begin
                        emit      = 1'b1;
                        state_nxt = ST_PASS;
                    end
                end
                ST_PASS: begin
                    state_nxt = ST_PASS;
                end
                default: begin
                    state_nxt = ST_ACC;
                end
            endcase
        end
    end

    assign done = (state == ST_DONE);

    // ------------------------------------------------------------------
    // Operand forwarding: unconditional, data moves even without its valid
    // ------------------------------------------------------------------
    // NOTE: sequential state is always written with non-blocking assignments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            south_data <= '0;
            south_vld  <= 1'b0;
            east_data  <= '0;
            east_vld   <= 1'b0;
        end else begin
            south_data <= north_data;
            south_vld  <= north_vld;
            east_data  <= west_data;
            east_vld   <= west_vld;
        end
    end

    // ------------------------------------------------------------------
    // Multiply-accumulate datapath
    // ------------------------------------------------------------------
    assign prod     = $signed(north_data) * $signed(west_data);
    assign prod_ext = ACC_W'(prod);
    assign acc_sum  = acc_q + prod_ext;

`ifdef SATURATE_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic add_ovf;

    // Signed overflow: both addends share a sign that the sum does not.
    assign add_ovf = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                     (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);
    assign acc_nxt = add_ovf ? (acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX) : acc_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (clear) begin
            ovf <= 1'b0;
        end else if (fire && add_ovf) begin
            ovf <= 1'b1;
        end
    end
`else
    assign acc_nxt = acc_sum;
    assign ovf     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            count <= '0;
        end else if (clear) begin
            acc_q <= '0;
            count <= '0;
        end else if (fire) begin
            acc_q <= acc_nxt;
            count <= count + 1'b1;
        end
    end

    assign acc_out = acc_q;

    // ------------------------------------------------------------------
    // Result chain: emit own sum once, then shift the column above downward
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_out     <= '0;
            res_out_vld <= 1'b0;
        end else if (clear) begin
            res_out_vld <= 1'b0;
        end else if (emit) begin
            res_out     <= acc_q;
            res_out_vld <= 1'b1;
        end else if (state == ST_PASS) begin
            if (res_in_vld) begin
                res_out <= res_in;
            end
            res_out_vld <= res_in_vld;
        end else begin
            res_out_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Self-checking bench for systolic_mac_pe: single PE, a 4-PE result column, and a
// narrow-accumulator instance for the wrap/saturate behaviour (SATURATE_EN aware).
module tb_systolic_mac_pe;

    localparam int DATA_W  = 8;
    localparam int K_LEN   = 8;
    localparam int ACC_W   = 2*DATA_W + $clog2(K_LEN);
    localparam int S_K     = 4;
    localparam int S_ACC_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // single PE
    logic              clear, nv, wv, unload, rinv;
    logic [DATA_W-1:0] nd, wd;
    logic [ACC_W-1:0]  rin;
    logic [DATA_W-1:0] sd, ed;
    logic              sv, ev, done, routv, ovf;
    logic [ACC_W-1:0]  acc, rout;

    systolic_mac_pe #(.DATA_W(DATA_W), .K_LEN(K_LEN), .ACC_W(ACC_W)) u_dut (
        .clk(clk), .rst(rst), .clear(clear),
        .north_data(nd), .north_vld(nv), .west_data(wd), .west_vld(wv),
        .south_data(sd), .south_vld(sv), .east_data(ed), .east_vld(ev),
        .acc_out(acc), .done(done), .unload(unload),
        .res_in(rin), .res_in_vld(rinv), .res_out(rout), .res_out_vld(routv),
        .ovf(ovf)
    );

    // 4-PE column, index 0 at the top
    logic              c_clear, c_unload;
    logic [DATA_W-1:0] c_nd[4], c_wd[4], c_sd[4], c_ed[4];
    logic              c_nv[4], c_wv[4], c_sv[4], c_ev[4];
    logic              c_done[4], c_ovf[4], c_rout_vld[4], c_rin_vld[4];
    logic [ACC_W-1:0]  c_acc[4], c_rout[4], c_rin[4];

    for (genvar g = 0; g < 4; g++) begin : g_col
        if (g == 0) begin : g_top
            assign c_rin[g]     = '0;
            assign c_rin_vld[g] = 1'b0;
        end else begin : g_chain
            assign c_rin[g]     = c_rout[g-1];
            assign c_rin_vld[g] = c_rout_vld[g-1];
        end
        systolic_mac_pe #(.DATA_W(DATA_W), .K_LEN(K_LEN), .ACC_W(ACC_W)) u_pe (
            .clk(clk), .rst(rst), .clear(c_clear),
            .north_data(c_nd[g]), .north_vld(c_nv[g]), .west_data(c_wd[g]), .west_vld(c_wv[g]),
            .south_data(c_sd[g]), .south_vld(c_sv[g]), .east_data(c_ed[g]), .east_vld(c_ev[g]),
            .acc_out(c_acc[g]), .done(c_done[g]), .unload(c_unload),
            .res_in(c_rin[g]), .res_in_vld(c_rin_vld[g]), .res_out(c_rout[g]),
            .res_out_vld(c_rout_vld[g]), .ovf(c_ovf[g])
        );
    end

    // narrow accumulator instance
    logic               s_clear, s_nv, s_wv;
    logic [DATA_W-1:0]  s_nd, s_wd, s_sd, s_ed;
    logic               s_sv, s_ev, s_done, s_routv, s_ovf;
    logic [S_ACC_W-1:0] s_acc, s_rout;

    systolic_mac_pe #(.DATA_W(DATA_W), .K_LEN(S_K), .ACC_W(S_ACC_W)) u_sat (
        .clk(clk), .rst(rst), .clear(s_clear),
        .north_data(s_nd), .north_vld(s_nv), .west_data(s_wd), .west_vld(s_wv),
        .south_data(s_sd), .south_vld(s_sv), .east_data(s_ed), .east_vld(s_ev),
        .acc_out(s_acc), .done(s_done), .unload(1'b0),
        .res_in('0), .res_in_vld(1'b0), .res_out(s_rout), .res_out_vld(s_routv),
        .ovf(s_ovf)
    );

    int checks   = 0;
    int failures = 0;
    logic [ACC_W-1:0] sb_q[$];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pair(input int n, input int w);
        nd = DATA_W'(n);
        wd = DATA_W'(w);
        nv = 1'b1;
        wv = 1'b1;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        nd = 8'h5a; wd = 8'ha5; nv = 1'b1; wv = 1'b1;
        clear = 1'b0; unload = 1'b0; rin = '1; rinv = 1'b1;
        c_clear = 1'b0; c_unload = 1'b0;
        for (int g = 0; g < 4; g++) begin
            c_nd[g] = '0; c_wd[g] = '0; c_nv[g] = 1'b0; c_wv[g] = 1'b0;
        end
        s_clear = 1'b0; s_nd = '0; s_wd = '0; s_nv = 1'b0; s_wv = 1'b0;
        #1;
        checks++;
        if ({sd, sv, ed, ev, acc, done, rout, routv, ovf} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {sd, sv, ed, ev, acc, done, rout, routv, ovf});
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({sd, sv, ed, ev, acc, done, rout, routv} !== '0) begin
            failures++;
            $display("FAIL reset_held got=%h exp=0", {sd, sv, ed, ev, acc, done, rout, routv});
        end
        nv = 1'b0; wv = 1'b0; rinv = 1'b0; rin = '0;
        release_rst();
    endtask

    task automatic test_column();
        int tgt[4] = '{10, 20, 30, 40};
        for (int k = 0; k < K_LEN; k++) begin
            for (int g = 0; g < 4; g++) begin
                c_nd[g] = (k == K_LEN-1) ? DATA_W'(tgt[g] - (K_LEN-1)) : DATA_W'(1);
                c_wd[g] = DATA_W'(1);
                c_nv[g] = 1'b1;
                c_wv[g] = 1'b1;
            end
            cyc();
        end
        for (int g = 0; g < 4; g++) begin
            c_nv[g] = 1'b0;
            c_wv[g] = 1'b0;
        end
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (c_done[g] !== 1'b1 || c_acc[g] !== ACC_W'(tgt[g])) begin
                failures++;
                $display("FAIL col_load pe=%0d got done=%b acc=%0d exp done=1 acc=%0d",
                         g, c_done[g], c_acc[g], tgt[g]);
            end
        end
        c_unload = 1'b1;
        for (int g = 3; g >= 0; g--) sb_q.push_back(ACC_W'(tgt[g]));
        cyc();
        c_unload = 1'b0;
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (c_rout_vld[3] !== 1'b1) begin
                failures++;
                $display("FAIL col_vld slot=%0d got=%b exp=1", n, c_rout_vld[3]);
            end else if (sb_q.size() != 0) begin
                logic [ACC_W-1:0] exp_r;
                exp_r = sb_q.pop_front();
                checks++;
                if (c_rout[3] !== exp_r) begin
                    failures++;
                    $display("FAIL col_data slot=%0d got=%0d exp=%0d", n, c_rout[3], exp_r);
                end
            end
            cyc();
        end
        checks++;
        if (c_rout_vld[3] !== 1'b0 || sb_q.size() != 0) begin
            failures++;
            $display("FAIL col_end got vld=%b left=%0d exp vld=0 left=0", c_rout_vld[3], sb_q.size());
        end
        sb_q.delete();
    endtask

    task automatic test_mac_basic();
        int model = 0;
        for (int i = 0; i < K_LEN; i++) begin
            drive_pair(3, -2);
            model += 3 * -2;
            cyc();
            checks++;
            if (sd !== nd || sv !== 1'b1 || ed !== wd || ev !== 1'b1) begin
                failures++;
                $display("FAIL fwd_basic i=%0d got s=%h/%b e=%h/%b exp s=%h/1 e=%h/1",
                         i, sd, sv, ed, ev, nd, wd);
            end
            checks++;
            if (done !== (i == K_LEN-1)) begin
                failures++;
                $display("FAIL done_timing i=%0d got=%b exp=%b", i, done, (i == K_LEN-1));
            end
        end
        nv = 1'b0; wv = 1'b0;
        checks++;
        if (acc !== ACC_W'(model)) begin
            failures++;
            $display("FAIL acc_basic got=%0d exp=%0d", $signed(acc), model);
        end
    endtask

    task automatic test_partial_vld();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        checks++;
        if (acc !== '0 || done !== 1'b0) begin
            failures++;
            $display("FAIL clear_acc got acc=%0d done=%b exp acc=0 done=0", acc, done);
        end
        for (int i = 0; i < 10; i++) begin
            nd = DATA_W'($urandom);
            wd = DATA_W'($urandom);
            nv = (i % 2 == 0);
            wv = !nv;
            cyc();
            checks++;
            if (sd !== nd || sv !== nv || ed !== wd || ev !== wv) begin
                failures++;
                $display("FAIL fwd_partial i=%0d got s=%h/%b e=%h/%b exp s=%h/%b e=%h/%b",
                         i, sd, sv, ed, ev, nd, nv, wd, wv);
            end
            checks++;
            if (acc !== '0 || done !== 1'b0) begin
                failures++;
                $display("FAIL partial_nofire i=%0d got acc=%0d done=%b exp acc=0 done=0", i, acc, done);
            end
        end
        for (int i = 0; i < K_LEN; i++) begin
            drive_pair(1, 1);
            cyc();
        end
        nv = 1'b0; wv = 1'b0;
        checks++;
        if (acc !== ACC_W'(8) || done !== 1'b1) begin
            failures++;
            $display("FAIL acc_ones got acc=%0d done=%b exp acc=8 done=1", acc, done);
        end
    endtask

    task automatic test_done_freeze();
        for (int i = 0; i < 4; i++) begin
            drive_pair(5, 5);
            cyc();
            checks++;
            if (acc !== ACC_W'(8) || done !== 1'b1) begin
                failures++;
                $display("FAIL done_frozen i=%0d got acc=%0d done=%b exp acc=8 done=1", i, acc, done);
            end
        end
        drive_pair(7, 7);
        clear = 1'b1;
        cyc();
        clear = 1'b0; nv = 1'b0; wv = 1'b0;
        checks++;
        if (acc !== '0 || done !== 1'b0) begin
            failures++;
            $display("FAIL clear_vs_fire got acc=%0d done=%b exp acc=0 done=0", acc, done);
        end
        for (int i = 0; i < K_LEN; i++) begin
            drive_pair(2, 3);
            cyc();
            checks++;
            if (done !== (i == K_LEN-1)) begin
                failures++;
                $display("FAIL count_restart i=%0d got=%b exp=%b", i, done, (i == K_LEN-1));
            end
        end
        nv = 1'b0; wv = 1'b0;
        checks++;
        if (acc !== ACC_W'(48)) begin
            failures++;
            $display("FAIL acc_after_clear got=%0d exp=48", acc);
        end
    endtask

    task automatic test_unload_pass();
        unload = 1'b1;
        sb_q.push_back(ACC_W'(48));
        cyc();
        unload = 1'b0;
        rin = ACC_W'(1234);
        rinv = 1'b1;
        sb_q.push_back(ACC_W'(1234));
        for (int n = 0; n < 2; n++) begin
            checks++;
            if (routv !== 1'b1) begin
                failures++;
                $display("FAIL pe_out_vld slot=%0d got=%b exp=1", n, routv);
            end else if (sb_q.size() != 0) begin
                logic [ACC_W-1:0] exp_r;
                exp_r = sb_q.pop_front();
                checks++;
                if (rout !== exp_r) begin
                    failures++;
                    $display("FAIL pe_out_data slot=%0d got=%0d exp=%0d", n, rout, exp_r);
                end
            end
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL done_after_unload slot=%0d got=%b exp=0", n, done);
            end
            if (n == 0) cyc();
        end
        rinv = 1'b0;
        unload = 1'b1;
        cyc();
        unload = 1'b0;
        checks++;
        if (routv !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL unload_in_pass got vld=%b done=%b exp vld=0 done=0", routv, done);
        end
        sb_q.delete();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({sd, sv, ed, ev, acc, done, rout, routv, ovf} !== '0) begin
            failures++;
            $display("FAIL rst_in_pass got=%h exp=0", {sd, sv, ed, ev, acc, done, rout, routv, ovf});
        end
        release_rst();
        for (int i = 0; i < 5; i++) begin
            drive_pair(1, 1);
            cyc();
        end
        checks++;
        if (acc !== ACC_W'(5)) begin
            failures++;
            $display("FAIL acc_five got=%0d exp=5", acc);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({sd, sv, ed, ev, acc, done, rout, routv, ovf} !== '0) begin
            failures++;
            $display("FAIL rst_in_acc got=%h exp=0", {sd, sv, ed, ev, acc, done, rout, routv, ovf});
        end
        nv = 1'b0; wv = 1'b0;
        release_rst();
        unload = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (routv !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL unload_in_acc i=%0d got vld=%b done=%b exp vld=0 done=0", i, routv, done);
            end
        end
        unload = 1'b0;
        for (int i = 0; i < K_LEN; i++) begin
            drive_pair(1, 1);
            cyc();
            checks++;
            if (done !== (i == K_LEN-1)) begin
                failures++;
                $display("FAIL count_after_rst i=%0d got=%b exp=%b", i, done, (i == K_LEN-1));
            end
        end
        nv = 1'b0; wv = 1'b0;
        checks++;
        if (acc !== ACC_W'(8)) begin
            failures++;
            $display("FAIL acc_after_rst got=%0d exp=8", acc);
        end
    endtask

    task automatic test_clear_priority();
        clear = 1'b1;
        unload = 1'b1;
        cyc();
        clear = 1'b0;
        checks++;
        if (routv !== 1'b0 || done !== 1'b0 || acc !== '0) begin
            failures++;
            $display("FAIL clear_vs_unload got vld=%b done=%b acc=%0d exp vld=0 done=0 acc=0",
                     routv, done, acc);
        end
        cyc();
        unload = 1'b0;
        checks++;
        if (routv !== 1'b0) begin
            failures++;
            $display("FAIL unload_after_clear got=%b exp=0", routv);
        end
    endtask

    task automatic test_saturate();
        logic [S_ACC_W-1:0] exp_acc;
        logic               exp_ovf;
`ifdef SATURATE_EN
        exp_acc = 16'h7fff;
        exp_ovf = 1'b1;
`else
        exp_acc = S_ACC_W'(3 * 127 * 127);
        exp_ovf = 1'b0;
`endif
        for (int i = 0; i < 3; i++) begin
            s_nd = DATA_W'(127);
            s_wd = DATA_W'(127);
            s_nv = 1'b1;
            s_wv = 1'b1;
            cyc();
        end
        s_nv = 1'b0; s_wv = 1'b0;
        checks++;
        if (s_acc !== exp_acc || s_ovf !== exp_ovf || s_done !== 1'b0) begin
            failures++;
            $display("FAIL ovf_result got acc=%0d ovf=%b done=%b exp acc=%0d ovf=%b done=0",
                     $signed(s_acc), s_ovf, s_done, $signed(exp_acc), exp_ovf);
        end
        repeat (2) cyc();
        checks++;
        if (s_ovf !== exp_ovf) begin
            failures++;
            $display("FAIL ovf_sticky got=%b exp=%b", s_ovf, exp_ovf);
        end
        s_clear = 1'b1;
        cyc();
        s_clear = 1'b0;
        checks++;
        if (s_acc !== '0 || s_ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear got acc=%0d ovf=%b exp acc=0 ovf=0", s_acc, s_ovf);
        end
    endtask

    initial begin
        test_reset();
        test_column();
        test_mac_basic();
        test_partial_vld();
        test_done_freeze();
        test_unload_pass();
        test_reset_mid();
        test_clear_priority();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/systolic_mac_pe.md
Name: systolic_mac_pe

Overview:
Parametrised processing element for the NxN systolic matrix-multiply array. It forwards operands east and south with valid qualifiers, and accumulates a fixed-length dot product of K_LEN valid operand pairs. It signals completion, then unloads results through a per-column result shift chain. The array instantiates one per grid point; the bottom PE of each column feeds the readout logic.

Parameters:
DATA_W, 8, operand width (signed two's complement)
K_LEN, 8, number of valid products per tile before DONE
ACC_W, 2*DATA_W+$clog2(K_LEN), accumulator/result width; must be >= 2*DATA_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
clear  in  1  synchronous tile start: zero accumulator, restart
north_data  in  DATA_W  operand from PE above
north_vld  in  1  north_data valid
west_data  in  DATA_W  operand from PE to the left
west_vld  in  1  west_data valid
south_data  out  DATA_W  registered copy of north_data
south_vld  out  1  registered copy of north_vld
east_data  out  DATA_W  registered copy of west_data
east_vld  out  1  registered copy of west_vld
acc_out  out  ACC_W  current accumulator value (registered)
done  out  1  high while state is DONE
unload  in  1  column unload strobe (broadcast to the whole column)
res_in  in  ACC_W  result from PE above (result chain)
res_in_vld  in  1  res_in valid
res_out  out  ACC_W  result toward PE below
res_out_vld  out  1  res_out valid
ovf  out  1  sticky overflow flag (see Optional Feature)

Behaviour:
- Reset (async, rst=1): every output reg = 0; accumulator = 0, count = 0, state = ACC.
- Forwarding: every cycle, regardless of state or clear, the *_data/*_vld outputs take the matching input. Latency is 1 cycle. Data is forwarded even when its vld is low.
- fire = north_vld & west_vld & (state==ACC) & ~clear.
- On fire, the accumulator gets acc + sign_extend(north_data*west_data) and count increments. The product is a full signed 2*DATA_W value, sign-extended to ACC_W.
- If only one vld is high: no fire, count is unchanged, operands still forward.
- States: ACC, DONE, PASS.
  - ACC -> DONE on the fire that makes count == K_LEN. done = 1 the cycle after that fire, and acc_out then holds the final sum.
  - DONE: accumulator is frozen and further valid pairs are ignored. On unload=1: res_out <= acc, res_out_vld <= 1 for one cycle, then -> PASS.
  - PASS: res_out <= res_in and res_out_vld <= res_in_vld every cycle (1-cycle latency). done = 0, and unload is ignored.
  - Resulting column order at the bottom PE after a broadcast unload at cycle t: own result at t+1, PE above at t+2, and so on, one per cycle with no gaps.
- unload in ACC or PASS: ignored. In ACC and DONE, res_out_vld = 0 except for the emit cycle, and res_in is ignored.
- clear (any state): acc = 0, count = 0, ovf = 0, res_out_vld = 0, state = ACC. clear has priority over a simultaneous fire (that product is discarded) and over unload.
- rst mid-tile or mid-unload: immediate return to the reset values. No partial result is emitted.
- res_out holds its last value when res_out_vld = 0.

Optional Feature:
- SATURATE_EN defined:
  - Signed add clamps to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) on overflow.
  - ovf is set and stays high until clear or rst.
- Not defined:
  - Two's-complement wrap modulo 2^ACC_W.
  - ovf is constant 0.

Test Plan:
- Reset then 8 valid pairs (3,-2) with K_LEN=8 -> acc_out=-48; done=1 one cycle after the 8th fire; east/south mirror inputs with 1-cycle delay throughout.
- Alternate cycles with only north_vld=1, then only west_vld=1, for 10 cycles -> acc_out stays 0, done stays 0; then 8 full pairs (1,1) -> acc_out=8.
- After done, 4 extra valid pairs (5,5) -> acc_out unchanged; clear coincident with a valid pair (7,7) -> acc_out=0, count=0, state ACC, product discarded.
- 4-PE column, each done with results 10,20,30,40 (top to bottom), unload pulse at cycle t -> bottom res_out = 40,30,20,10 on cycles t+1..t+4 with res_out_vld=1 each cycle, 0 at t+5.
- Assert rst during ACC after 5 fires and during PASS -> all outputs 0 immediately, state ACC; unload while in ACC -> res_out_vld stays 0.
- DATA_W=8, ACC_W=16, K_LEN=4, pairs (127,127) x3 -> with SATURATE_EN: acc_out=32767, ovf=1 until clear. Without: acc_out=48387 mod 2^16 = -17149, ovf=0.
